usb_acia: RTL and testbench
===========================

USB_ACIA -- requirements
Module: usb_acia

Interface
REQ-001 Parameter: CLKS_PER_BIT, default 434, clk cycles per serial bit (50 MHz / 115200); legal range 16..65535.
REQ-002 Port: clk  input  1  system clock; all logic on rising edge.
REQ-003 Port: reset  input  1  synchronous, active-high reset.
REQ-004 Port: E  input  1  CPU E clock, synchronous to clk.
REQ-005 Port: usbSelect  input  1  chip select from the address decoder; active high for 0xE010-0xE011 during E.
REQ-006 Port: rs  input  1  register select (address[0]).
REQ-007 Port: readNotWrite  input  1  1 = CPU read, 0 = CPU write.
REQ-008 Port: dataIn  input  8  CPU write data.
REQ-009 Port: dataOut  output  8  CPU read data.
REQ-010 Port: irqN  output  1  active-low interrupt request.
REQ-011 Port: txd  output  1  serial transmit, idle high.
REQ-012 Port: rxd  input  1  serial receive, asynchronous, idle high.

Function
REQ-013 Register map: rs=0 read = status, rs=0 write = control, rs=1 read = RX data, rs=1 write = TX data.
REQ-014 Access commit point: the clk cycle in which E is 0 and E was 1 on the previous cycle (E falling edge), with usbSelect=1 at that previous cycle; exactly one commit per E cycle.
REQ-015 dataOut is combinational: status when rs=0, RX data register when rs=1; it is valid whenever usbSelect=1 and readNotWrite=1, and is 0x00 otherwise.
REQ-016 Status bits: [0] RDRF, [1] TDRE, [4] FE, [5] OVRN, [7] IRQ; bits 6, 3, 2 read 0.
REQ-017 Control write: when dataIn[1:0]=11, master reset (same as REQ-030, except the CLKS_PER_BIT counters); otherwise the write stores RIE=dataIn[7] and TIE=(dataIn[6:5]==01).
REQ-018 IRQ = (RIE & (RDRF | OVRN)) | (TIE & TDRE); irqN = ~IRQ, registered (one clk latency).
REQ-019 TX data write: loads the holding register and clears TDRE; a write while TDRE=0 overwrites the holding byte (no error flag).
REQ-020 TX FSM states are IDLE, START, DATA, STOP; each state holds for CLKS_PER_BIT cycles.
REQ-021 TX FSM transitions: IDLE->START when TDRE=0 (holding register moves to shifter, TDRE set the same cycle); START->DATA; DATA->STOP after 8 bits, LSB first; STOP->START if TDRE=0, else IDLE; no idle gap between back-to-back bytes.
REQ-022 rxd passes through a 2-flop synchronizer before use.
REQ-023 RX FSM states are IDLE, START, DATA, STOP.
REQ-024 RX IDLE->START on a synchronized falling edge.
REQ-025 RX START samples at CLKS_PER_BIT/2; if the line is high (glitch), the FSM returns to IDLE; otherwise it goes to DATA.
REQ-026 RX DATA samples 8 bits at one CLKS_PER_BIT interval each, LSB first.
REQ-027 RX STOP samples one bit time after the last data bit, then goes to IDLE.
REQ-028 RX byte completion at the stop sample: if RDRF=0, the data register is loaded, RDRF is set, and FE = stop bit is 0. If RDRF=1, the byte is discarded, OVRN is set, and the data register and FE are unchanged.
REQ-029 An RX data read commit clears RDRF, OVRN and FE; if byte completion and the read commit occur in the same cycle, the completion wins (RDRF=1, new data loaded).

Reset
REQ-030 On reset the outputs are: dataOut=0x00 (no select), irqN=1, txd=1.
REQ-031 On reset the flags are: RDRF=0, TDRE=1, FE=0, OVRN=0, RIE=0, TIE=0.
REQ-032 On reset both FSMs go to IDLE and all counters clear; a reset mid-frame aborts the frame, with txd high on the next cycle.

Verification
REQ-033 TX byte: write 0x55 to rs=1 -> TDRE=0 then 1 within 2 clks; txd shows start 0, bits 1,0,1,0,1,0,1,0, stop 1, each CLKS_PER_BIT wide.
REQ-034 RX byte: drive serial 0xA5 on rxd -> RDRF=1 within CLKS_PER_BIT/2+4 clks after the stop midpoint; RX read returns 0xA5; RDRF=0 after the read commit.
REQ-035 Overrun: receive 0x11 then 0x22 without reading -> status reads 0x23 with TDRE=1 (RDRF, TDRE, OVRN set); data read returns 0x11, then status reads 0x02.
REQ-036 Framing: send 0x3C with stop bit 0 -> RDRF=1, FE=1; data register = 0x3C.
REQ-037 Interrupts: write control 0x80, receive a byte -> irqN=0; read data -> irqN=1; write control 0x20 -> irqN=0 (TDRE=1).
REQ-038 Master reset: during TX of 0xFF, write control 0x03 -> txd=1 next cycle; status reads 0x02.

Source files
------------

// File: rtl/usb_acia.sv
`default_nettype none
// ============================================================================
// Module      : usb_acia
// Description : 6850-style ACIA for a USB-serial bridge: CPU register
//               interface with E-clock commit, 8N1 transmitter and receiver.
// Revision    : 1.0 - initial release
// ============================================================================
module usb_acia #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       E,
    input  logic       usbSelect,
    input  logic       rs,
    input  logic       readNotWrite,
    input  logic [7:0] dataIn,
    output logic [7:0] dataOut,
    output logic       irqN,
    output logic       txd,
    input  logic       rxd
);
    localparam logic [15:0] c_BIT_LAST  = 16'(CLKS_PER_BIT - 1);
    localparam logic [15:0] c_HALF_LAST = 16'(CLKS_PER_BIT / 2 - 1);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_START = 2'd1;
    localparam logic [1:0] c_DATA  = 2'd2;
    localparam logic [1:0] c_STOP  = 2'd3;

    // Bus attributes are captured while E is high and committed on its fall.
    logic       r_prevE;
    logic       r_prevSel;
    logic       r_prevRs;
    logic       r_prevRnw;
    logic [7:0] r_prevData;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_prevE    <= 1'b0;
            r_prevSel  <= 1'b0;
            r_prevRs   <= 1'b0;
            r_prevRnw  <= 1'b0;
            r_prevData <= 8'h00;
        end else begin
            r_prevE    <= E;
            r_prevSel  <= usbSelect;
            r_prevRs   <= rs;
            r_prevRnw  <= readNotWrite;
            r_prevData <= dataIn;
        end
    end

    logic w_commit;
    logic w_ctrlWrite;
    logic w_masterReset;
    logic w_txWrite;
    logic w_rxRead;

    assign w_commit      = r_prevE & r_prevSel & ~E;
    assign w_ctrlWrite   = w_commit & ~r_prevRs & ~r_prevRnw;
    assign w_masterReset = w_ctrlWrite & (r_prevData[1:0] == 2'b11);
    assign w_txWrite     = w_commit & r_prevRs & ~r_prevRnw;
    assign w_rxRead      = w_commit & r_prevRs & r_prevRnw;

    logic r_rie;
    logic r_tie;

    always_ff @(posedge clk) begin
        if (reset || w_masterReset) begin
            r_rie <= 1'b0;
            r_tie <= 1'b0;
        end else if (w_ctrlWrite) begin
            r_rie <= r_prevData[7];
            r_tie <= (r_prevData[6:5] == 2'b01);
        end
    end

    // ------------------------------------------------------------------ TX
    logic [1:0]  r_txState;
    logic [15:0] r_txCnt;
    logic [2:0]  r_txBit;
    logic [7:0]  r_txShift;
    logic [7:0]  r_txHold;
    logic        r_tdre;
    logic        r_txd;
    logic        w_txBitEnd;

    assign w_txBitEnd = (r_txCnt == c_BIT_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_txState <= c_IDLE;
            r_txCnt   <= 16'd0;
            r_txBit   <= 3'd0;
            r_txShift <= 8'h00;
            r_txHold  <= 8'h00;
            r_tdre    <= 1'b1;
            r_txd     <= 1'b1;
        end else if (w_masterReset) begin
            r_txState <= c_IDLE;
            r_txBit   <= 3'd0;
            r_tdre    <= 1'b1;
            r_txd     <= 1'b1;
        end else begin
            if (r_txState != c_IDLE)
                r_txCnt <= w_txBitEnd ? 16'd0 : r_txCnt + 16'd1;
            case (r_txState)
                c_IDLE: begin
                    if (!r_tdre) begin
                        r_txShift <= r_txHold;
                        r_tdre    <= 1'b1;
                        r_txCnt   <= 16'd0;
                        r_txd     <= 1'b0;
                        r_txState <= c_START;
                    end
                end
                c_START: begin
                    if (w_txBitEnd) begin
                        r_txd     <= r_txShift[0];
                        r_txBit   <= 3'd0;
                        r_txState <= c_DATA;
                    end
                end
                c_DATA: begin
                    if (w_txBitEnd) begin
                        if (r_txBit == 3'd7) begin
                            r_txd     <= 1'b1;
                            r_txState <= c_STOP;
                        end else begin
                            r_txd     <= r_txShift[1];
                            r_txShift <= {1'b0, r_txShift[7:1]};
                            r_txBit   <= r_txBit + 3'd1;
                        end
                    end
                end
                default: begin
                    if (w_txBitEnd) begin
                        // Chain straight into the next start bit when a byte waits.
                        if (!r_tdre) begin
                            r_txShift <= r_txHold;
                            r_tdre    <= 1'b1;
                            r_txd     <= 1'b0;
                            r_txState <= c_START;
                        end else begin
                            r_txState <= c_IDLE;
                        end
                    end
                end
            endcase
            if (w_txWrite) begin
                r_txHold <= r_prevData;
                r_tdre   <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------ RX
    logic r_rxSync1;
    logic r_rxSync2;
    logic r_rxPrev;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rxSync1 <= 1'b1;
            r_rxSync2 <= 1'b1;
            r_rxPrev  <= 1'b1;
        end else begin
            r_rxSync1 <= rxd;
            r_rxSync2 <= r_rxSync1;
            r_rxPrev  <= r_rxSync2;
        end
    end

    logic [1:0]  r_rxState;
    logic [15:0] r_rxCnt;
    logic [2:0]  r_rxBit;
    logic [7:0]  r_rxShift;
    logic [7:0]  r_rxData;
    logic        r_rdrf;
    logic        r_ovrn;
    logic        r_fe;
    logic        w_rdrfHeld;

    // A read committing alongside completion frees the register for the new byte.
    assign w_rdrfHeld = r_rdrf & ~w_rxRead;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rxState <= c_IDLE;
            r_rxCnt   <= 16'd0;
            r_rxBit   <= 3'd0;
            r_rxShift <= 8'h00;
            r_rxData  <= 8'h00;
            r_rdrf    <= 1'b0;
            r_ovrn    <= 1'b0;
            r_fe      <= 1'b0;
        end else if (w_masterReset) begin
            r_rxState <= c_IDLE;
            r_rxBit   <= 3'd0;
            r_rdrf    <= 1'b0;
            r_ovrn    <= 1'b0;
            r_fe      <= 1'b0;
        end else begin
            if (w_rxRead) begin
                r_rdrf <= 1'b0;
                r_ovrn <= 1'b0;
                r_fe   <= 1'b0;
            end
            case (r_rxState)
                c_IDLE: begin
                    if (r_rxPrev && !r_rxSync2) begin
                        r_rxCnt   <= 16'd0;
                        r_rxState <= c_START;
                    end
                end
                c_START: begin
                    if (r_rxCnt == c_HALF_LAST) begin
                        r_rxCnt   <= 16'd0;
                        r_rxBit   <= 3'd0;
                        r_rxState <= r_rxSync2 ? c_IDLE : c_DATA;
                    end else begin
                        r_rxCnt <= r_rxCnt + 16'd1;
                    end
                end
                c_DATA: begin
                    if (r_rxCnt == c_BIT_LAST) begin
                        r_rxCnt   <= 16'd0;
                        r_rxShift <= {r_rxSync2, r_rxShift[7:1]};
                        r_rxBit   <= r_rxBit + 3'd1;
                        if (r_rxBit == 3'd7)
                            r_rxState <= c_STOP;
                    end else begin
                        r_rxCnt <= r_rxCnt + 16'd1;
                    end
                end
                default: begin
                    if (r_rxCnt == c_BIT_LAST) begin
                        r_rxCnt   <= 16'd0;
                        r_rxState <= c_IDLE;
                        if (w_rdrfHeld) begin
                            r_ovrn <= 1'b1;
                        end else begin
                            r_rxData <= r_rxShift;
                            r_rdrf   <= 1'b1;
                            r_fe     <= ~r_rxSync2;
                        end
                    end else begin
                        r_rxCnt <= r_rxCnt + 16'd1;
                    end
                end
            endcase
        end
    end

    // ------------------------------------------------------------ CPU side
    logic       w_irq;
    logic [7:0] w_status;
    logic       r_irqN;

    assign w_irq    = (r_rie & (r_rdrf | r_ovrn)) | (r_tie & r_tdre);
    assign w_status = {w_irq, 1'b0, r_ovrn, r_fe, 2'b00, r_tdre, r_rdrf};

    always_ff @(posedge clk) begin
        if (reset || w_masterReset)
            r_irqN <= 1'b1;
        else
            r_irqN <= ~w_irq;
    end

    assign dataOut = (usbSelect && readNotWrite) ? (rs ? r_rxData : w_status) : 8'h00;
    assign irqN    = r_irqN;
    assign txd     = r_txd;

endmodule
`default_nettype wire

// File: tb/tb_usb_acia.sv
`default_nettype none
// ============================================================================
// Module      : tb_usb_acia
// Description : Self-checking bench for usb_acia against a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_usb_acia;
    localparam int CPB = 16;

    logic       clk = 1'b0;
    logic       reset;
    logic       E;
    logic       usbSelect;
    logic       rs;
    logic       readNotWrite;
    logic [7:0] dataIn;
    logic [7:0] dataOut;
    logic       irqN;
    logic       txd;
    logic       rxd;

    usb_acia #(.CLKS_PER_BIT(CPB)) dut (
        .clk          (clk),
        .reset        (reset),
        .E            (E),
        .usbSelect    (usbSelect),
        .rs           (rs),
        .readNotWrite (readNotWrite),
        .dataIn       (dataIn),
        .dataOut      (dataOut),
        .irqN         (irqN),
        .txd          (txd),
        .rxd          (rxd)
    );

    always #5 clk = ~clk;

    int nChecks = 0;
    int nPass   = 0;

    // Reference model of the register-visible state.
    logic       mRdrf, mOvrn, mFe, mRie, mTie;
    logic [7:0] mRxData;
    logic       txTrace[$];
    logic       expWave[$];

    function automatic void modelReset();
        mRdrf = 0; mOvrn = 0; mFe = 0; mRie = 0; mTie = 0;
    endfunction

    // Status as seen while the transmitter has nothing pending (TDRE=1).
    function automatic logic [7:0] expStatus();
        logic irq;
        irq = (mRie & (mRdrf | mOvrn)) | mTie;
        return {irq, 1'b0, mOvrn, mFe, 2'b00, 1'b1, mRdrf};
    endfunction

    function automatic void modelRxFrame(input logic [7:0] b, input logic stopBit);
        if (!mRdrf) begin
            mRxData = b; mRdrf = 1; mFe = ~stopBit;
        end else begin
            mOvrn = 1;
        end
    endfunction

    function automatic logic [7:0] modelRxRead();
        mRdrf = 0; mOvrn = 0; mFe = 0;
        return mRxData;
    endfunction

    function automatic void addFrame(input logic [7:0] b);
        for (int i = 0; i < CPB; i++) expWave.push_back(1'b0);
        for (int k = 0; k < 8; k++)
            for (int i = 0; i < CPB; i++) expWave.push_back(b[k]);
        for (int i = 0; i < CPB; i++) expWave.push_back(1'b1);
    endfunction

    task automatic cpuWrite(input logic r, input logic [7:0] d);
        @(negedge clk);
        usbSelect = 1; E = 1; rs = r; readNotWrite = 0; dataIn = d;
        repeat (2) @(negedge clk);
        E = 0;
        @(negedge clk);
        usbSelect = 0; dataIn = 8'h00;
    endtask

    task automatic cpuRead(input logic r, output logic [7:0] d);
        @(negedge clk);
        usbSelect = 1; E = 1; rs = r; readNotWrite = 1;
        repeat (2) @(negedge clk);
        d = dataOut;
        E = 0;
        @(negedge clk);
        usbSelect = 0; readNotWrite = 0;
    endtask

    // Combinational status look without an E pulse, so nothing commits.
    task automatic peekStatus(output logic [7:0] d);
        usbSelect = 1; readNotWrite = 1; rs = 0;
        #1 d = dataOut;
        usbSelect = 0; readNotWrite = 0;
    endtask

    task automatic sendSerial(input logic [7:0] b, input logic stopBit);
        @(negedge clk);
        rxd = 0;
        repeat (CPB) @(negedge clk);
        for (int k = 0; k < 8; k++) begin
            rxd = b[k];
            repeat (CPB) @(negedge clk);
        end
        rxd = stopBit;
        repeat (CPB) @(negedge clk);
        rxd = 1;
        repeat (4) @(negedge clk);
        modelRxFrame(b, stopBit);
    endtask

    // Records txd from the first start-bit cycle for the frames plus one idle bit.
    task automatic captureTx(input int nFrames);
        int waited;
        txTrace.delete();
        waited = 0;
        @(negedge clk);
        while (txd !== 1'b0 && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        if (txd !== 1'b0) begin
            nChecks++;
            $display("FAIL tx_start_timeout: txd=%b after %0d cycles, want 0", txd, waited);
        end else begin
            for (int i = 0; i < (nFrames * 10 + 1) * CPB; i++) begin
                txTrace.push_back(txd);
                @(negedge clk);
            end
        end
    endtask

    task automatic test_reset();
        logic [7:0] s;
        reset = 1;
        repeat (4) @(negedge clk);
        nChecks++;
        if (irqN !== 1'b1) $display("FAIL reset_irqN: got %b want 1", irqN); else nPass++;
        nChecks++;
        if (txd !== 1'b1) $display("FAIL reset_txd: got %b want 1", txd); else nPass++;
        nChecks++;
        if (dataOut !== 8'h00) $display("FAIL reset_dataOut: got %h want 00", dataOut); else nPass++;
        reset = 0;
        modelReset();
        @(negedge clk);
        peekStatus(s);
        nChecks++;
        if (s !== 8'h02) $display("FAIL reset_status: got %h want 02", s); else nPass++;
        usbSelect = 1; readNotWrite = 0; rs = 0;
        #1;
        nChecks++;
        if (dataOut !== 8'h00) $display("FAIL write_dataOut: got %h want 00", dataOut); else nPass++;
        usbSelect = 0;
    endtask

    task automatic test_tx();
        logic [7:0] s0, s1, b;
        int mis;
        for (int n = 0; n < 4; n++) begin
            b = (n == 0) ? 8'h55 : 8'($urandom);
            fork
                captureTx(1);
                begin
                    cpuWrite(1, b);
                    peekStatus(s0);
                    @(negedge clk);
                    peekStatus(s1);
                end
            join
            if (n == 0) begin
                nChecks++;
                if (s0[1] !== 1'b0 || s1[1] !== 1'b1)
                    $display("FAIL tx_tdre_pulse: got %b then %b want 0 then 1", s0[1], s1[1]);
                else nPass++;
            end
            expWave.delete();
            addFrame(b);
            for (int i = 0; i < CPB; i++) expWave.push_back(1'b1);
            mis = (txTrace.size() == expWave.size()) ? -1 : 0;
            for (int i = 0; i < txTrace.size() && mis < 0; i++)
                if (txTrace[i] !== expWave[i]) mis = i;
            nChecks++;
            if (mis >= 0)
                $display("FAIL tx_frame %h: cycle %0d got %b want %b (len %0d want %0d)", b, mis,
                         (mis < txTrace.size()) ? txTrace[mis] : 1'bx, expWave[mis],
                         txTrace.size(), expWave.size());
            else nPass++;
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] b0, b1;
        int mis;
        b0 = 8'($urandom);
        b1 = 8'($urandom);
        fork
            captureTx(2);
            begin
                cpuWrite(1, b0);
                cpuWrite(1, b1);
            end
        join
        expWave.delete();
        addFrame(b0);
        addFrame(b1);
        for (int i = 0; i < CPB; i++) expWave.push_back(1'b1);
        mis = (txTrace.size() == expWave.size()) ? -1 : 0;
        for (int i = 0; i < txTrace.size() && mis < 0; i++)
            if (txTrace[i] !== expWave[i]) mis = i;
        nChecks++;
        if (mis >= 0)
            $display("FAIL tx_back_to_back %h %h: cycle %0d got %b want %b", b0, b1, mis,
                     (mis < txTrace.size()) ? txTrace[mis] : 1'bx, expWave[mis]);
        else nPass++;
    endtask

    task automatic test_rx();
        logic [7:0] s, d, b, e;
        logic       stopBit;
        for (int n = 0; n < 5; n++) begin
            b       = (n == 0) ? 8'hA5 : 8'($urandom);
            stopBit = (n == 0) ? 1'b1 : ($urandom_range(0, 3) != 0);
            sendSerial(b, stopBit);
            peekStatus(s);
            nChecks++;
            if (s !== expStatus()) $display("FAIL rx_status %h: got %h want %h", b, s, expStatus());
            else nPass++;
            cpuRead(1, d);
            e = modelRxRead();
            nChecks++;
            if (d !== e) $display("FAIL rx_data: got %h want %h", d, e); else nPass++;
            peekStatus(s);
            nChecks++;
            if (s !== expStatus()) $display("FAIL rx_after_read: got %h want %h", s, expStatus());
            else nPass++;
        end
    endtask

    task automatic test_overrun();
        logic [7:0] s, d, e;
        sendSerial(8'h11, 1'b1);
        sendSerial(8'h22, 1'b1);
        peekStatus(s);
        nChecks++;
        if (s !== expStatus() || s !== 8'h23)
            $display("FAIL ovrn_status: got %h want %h", s, expStatus());
        else nPass++;
        cpuRead(1, d);
        e = modelRxRead();
        nChecks++;
        if (d !== e) $display("FAIL ovrn_data: got %h want %h", d, e); else nPass++;
        peekStatus(s);
        nChecks++;
        if (s !== expStatus()) $display("FAIL ovrn_cleared: got %h want %h", s, expStatus());
        else nPass++;
    endtask

    task automatic test_framing();
        logic [7:0] s, d, e;
        sendSerial(8'h3C, 1'b0);
        peekStatus(s);
        nChecks++;
        if (s !== expStatus()) $display("FAIL fe_status: got %h want %h", s, expStatus());
        else nPass++;
        cpuRead(1, d);
        e = modelRxRead();
        nChecks++;
        if (d !== e) $display("FAIL fe_data: got %h want %h", d, e); else nPass++;
    endtask

    task automatic test_glitch();
        logic [7:0] s, d, e;
        @(negedge clk);
        rxd = 0;
        repeat (3) @(negedge clk);
        rxd = 1;
        repeat (2 * CPB) @(negedge clk);
        peekStatus(s);
        nChecks++;
        if (s !== expStatus()) $display("FAIL glitch_status: got %h want %h", s, expStatus());
        else nPass++;
        sendSerial(8'($urandom), 1'b1);
        cpuRead(1, d);
        e = modelRxRead();
        nChecks++;
        if (d !== e) $display("FAIL glitch_recover: got %h want %h", d, e); else nPass++;
    endtask

    task automatic test_irq();
        logic [7:0] s, d, e;
        logic       expN;
        cpuWrite(0, 8'h80);
        mRie = 1; mTie = 0;
        @(negedge clk);
        nChecks++;
        if (irqN !== 1'b1) $display("FAIL irq_idle: got %b want 1", irqN); else nPass++;
        sendSerial(8'($urandom), 1'b1);
        peekStatus(s);
        expN = ~expStatus()[7];
        nChecks++;
        if (irqN !== expN || s !== expStatus())
            $display("FAIL irq_rx: got irqN=%b status=%h want irqN=%b status=%h", irqN, s, expN, expStatus());
        else nPass++;
        cpuRead(1, d);
        e = modelRxRead();
        @(negedge clk);
        nChecks++;
        if (irqN !== 1'b1 || d !== e)
            $display("FAIL irq_after_read: got irqN=%b data=%h want 1 %h", irqN, d, e);
        else nPass++;
        cpuWrite(0, 8'h20);
        mRie = 0; mTie = 1;
        @(negedge clk);
        nChecks++;
        if (irqN !== 1'b0) $display("FAIL irq_tie: got %b want 0", irqN); else nPass++;
        cpuWrite(0, 8'h00);
        mTie = 0;
        @(negedge clk);
        nChecks++;
        if (irqN !== 1'b1) $display("FAIL irq_disabled: got %b want 1", irqN); else nPass++;
    endtask

    task automatic test_master_reset();
        logic [7:0] s;
        int lows;
        cpuWrite(0, 8'h20);
        mTie = 1;
        sendSerial(8'h5A, 1'b1);
        sendSerial(8'hC3, 1'b1);
        peekStatus(s);
        nChecks++;
        if (s !== expStatus()) $display("FAIL mr_pre_status: got %h want %h", s, expStatus());
        else nPass++;
        cpuWrite(1, 8'hFF);
        @(negedge clk);
        nChecks++;
        if (txd !== 1'b0) $display("FAIL mr_tx_started: got %b want 0", txd); else nPass++;
        cpuWrite(0, 8'h03);
        modelReset();
        nChecks++;
        if (txd !== 1'b1) $display("FAIL mr_txd: got %b want 1", txd); else nPass++;
        peekStatus(s);
        nChecks++;
        if (s !== 8'h02) $display("FAIL mr_status: got %h want 02", s); else nPass++;
        @(negedge clk);
        nChecks++;
        if (irqN !== 1'b1) $display("FAIL mr_irqN: got %b want 1", irqN); else nPass++;
        lows = 0;
        for (int i = 0; i < 3 * CPB; i++) begin
            @(negedge clk);
            if (txd !== 1'b1) lows++;
        end
        nChecks++;
        if (lows != 0) $display("FAIL mr_tx_quiet: got %0d low cycles want 0", lows); else nPass++;
    endtask

    task automatic test_reset_midframe();
        logic [7:0] s;
        cpuWrite(1, 8'h00);
        repeat (3) @(negedge clk);
        reset = 1;
        @(negedge clk);
        nChecks++;
        if (txd !== 1'b1) $display("FAIL hard_reset_txd: got %b want 1", txd); else nPass++;
        reset = 0;
        modelReset();
        repeat (2 * CPB) @(negedge clk);
        peekStatus(s);
        nChecks++;
        if (s !== 8'h02 || txd !== 1'b1)
            $display("FAIL hard_reset_idle: got status %h txd %b want 02 1", s, txd);
        else nPass++;
    endtask

    initial begin
        reset = 1; E = 0; usbSelect = 0; rs = 0; readNotWrite = 0; dataIn = 8'h00; rxd = 1;
        modelReset();
        mRxData = 8'h00;
        test_reset();
        test_tx();
        test_back_to_back();
        test_rx();
        test_overrun();
        test_framing();
        test_glitch();
        test_irq();
        test_master_reset();
        test_reset_midframe();
        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1);
    end

endmodule
`default_nettype wire
